// File: rtl/uart_axil_master_bridge.sv
// UART byte-stream to AXI4-Lite master bridge.
// Decodes 'W'/'R' frames into single AXI4-Lite transactions and returns 'K'/'E' (+ read data) replies.
module uart_axil_master_bridge #(
   parameter int C_DATA_WIDTH   = 32,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                      clk,
   input  logic                      nrst,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic [7:0]                tx_data,
   output logic                      tx_valid,
   input  logic                      tx_ready,
   output logic                      rx_overrun,
   output logic [C_DATA_WIDTH-1:0]   awaddr,
   output logic [2:0]                awprot,
   output logic                      awvalid,
   input  logic                      awready,
   output logic [C_DATA_WIDTH-1:0]   wdata,
   output logic [C_DATA_WIDTH/8-1:0] wstrb,
   output logic                      wvalid,
   input  logic                      wready,
   input  logic [1:0]                bresp,
   input  logic                      bvalid,
   output logic                      bready,
   output logic [C_DATA_WIDTH-1:0]   araddr,
   output logic [2:0]                arprot,
   output logic                      arvalid,
   input  logic                      arready,
   input  logic [C_DATA_WIDTH-1:0]   rdata,
   input  logic [1:0]                rresp,
   input  logic                      rvalid,
   output logic                      rready
);

   localparam int          TW     = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0]  OP_WR  = 8'h57;
   localparam logic [7:0]  OP_RD  = 8'h52;
   localparam logic [7:0]  RPL_OK = 8'h4B;
   localparam logic [7:0]  RPL_ER = 8'h45;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_GET_ADDR, S_GET_DATA, S_WR_REQ, S_WR_RESP, S_RD_REQ, S_RD_RESP, S_SEND
   } state_t;

   state_t                  state_q, state_d;
   logic                    is_wr_q, is_wr_d;
   logic [1:0]              cnt_q, cnt_d;
   logic [TW-1:0]           tmo_q, tmo_d;
   logic [C_DATA_WIDTH-1:0] addr_q, addr_d;
   logic [C_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                    aw_done_q, aw_done_d;
   logic                    w_done_q, w_done_d;
   logic [C_DATA_WIDTH+7:0] reply_q, reply_d;
   logic [2:0]              len_q, len_d;
   logic                    ovr_q, ovr_d;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q   <= S_IDLE;
         is_wr_q   <= 1'b0;
         cnt_q     <= '0;
         tmo_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         reply_q   <= '0;
         len_q     <= '0;
         ovr_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         is_wr_q   <= is_wr_d;
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         reply_q   <= reply_d;
         len_q     <= len_d;
         ovr_q     <= ovr_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      is_wr_d   = is_wr_q;
      cnt_d     = cnt_q;
      tmo_d     = tmo_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      reply_d   = reply_q;
      len_d     = len_q;
      ovr_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            tmo_d = '0;
            cnt_d = '0;
            if (rx_valid && (rx_data == OP_WR || rx_data == OP_RD)) begin
               is_wr_d = (rx_data == OP_WR);
               state_d = S_GET_ADDR;
            end
         end
         S_GET_ADDR, S_GET_DATA: begin
            if (rx_valid) begin
               tmo_d = '0;
               cnt_d = cnt_q + 2'd1;
               if (state_q == S_GET_ADDR) begin
                  addr_d = {addr_q[C_DATA_WIDTH-9:0], rx_data};
               end else begin
                  wdata_d = {wdata_q[C_DATA_WIDTH-9:0], rx_data};
               end
               if (cnt_q == 2'd3) begin
                  aw_done_d = 1'b0;
                  w_done_d  = 1'b0;
                  if (state_q == S_GET_DATA) begin
                     state_d = S_WR_REQ;
                  end else begin
                     state_d = is_wr_q ? S_GET_DATA : S_RD_REQ;
                  end
               end
            end else if (tmo_q == TMO_LAST) begin
               state_d = S_IDLE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_WR_REQ: begin
            // Address and data channels complete independently; move on once both are done.
            if (awready) aw_done_d = 1'b1;
            if (wready)  w_done_d  = 1'b1;
            if (aw_done_d && w_done_d) state_d = S_WR_RESP;
         end
         S_WR_RESP: begin
            if (bvalid) begin
               reply_d = {(bresp == 2'b00) ? RPL_OK : RPL_ER, {C_DATA_WIDTH{1'b0}}};
               len_d   = 3'd1;
               state_d = S_SEND;
            end
         end
         S_RD_REQ: begin
            if (arready) state_d = S_RD_RESP;
         end
         S_RD_RESP: begin
            if (rvalid) begin
               if (rresp == 2'b00) begin
                  reply_d = {RPL_OK, rdata};
                  len_d   = 3'd5;
               end else begin
                  reply_d = {RPL_ER, {C_DATA_WIDTH{1'b0}}};
                  len_d   = 3'd1;
               end
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (tx_ready) begin
               reply_d = {reply_q[C_DATA_WIDTH-1:0], 8'h00};
               len_d   = len_q - 3'd1;
               if (len_q == 3'd1) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (rx_valid && state_q != S_IDLE && state_q != S_GET_ADDR && state_q != S_GET_DATA) begin
         ovr_d = 1'b1;
      end
   end

   assign tx_data    = reply_q[C_DATA_WIDTH+7 -: 8];
   assign tx_valid   = (state_q == S_SEND);
   assign rx_overrun = ovr_q;
   assign awaddr     = addr_q;
   assign awprot     = '0;
   assign awvalid    = (state_q == S_WR_REQ) && !aw_done_q;
   assign wdata      = wdata_q;
   assign wstrb      = '1;
   assign wvalid     = (state_q == S_WR_REQ) && !w_done_q;
   assign bready     = (state_q == S_WR_RESP);
   assign araddr     = addr_q;
   assign arprot     = '0;
   assign arvalid    = (state_q == S_RD_REQ);
   assign rready     = (state_q == S_RD_RESP);

endmodule
